// File: rtl/ctrl_sequencer.sv
// Microcoded control sequencer: T-state counter, opcode/flag decode and run/halt state.
// Optional single-step front end enabled by defining CTRL_SEQUENCER_SINGLE_STEP_EN.
module ctrl_sequencer #(
    parameter int MAX_STEPS    = 5,
    parameter bit RESET_HALTED = 1'b0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [3:0]  i_opcode,
    input  logic        i_flag_c,
    input  logic        i_flag_z,
    input  logic        i_run,
`ifdef CTRL_SEQUENCER_SINGLE_STEP_EN
    input  logic        i_step_mode,
    input  logic        i_step_btn,
    output logic        o_step_tick,
`endif
    output logic [15:0] o_ctrl,
    output logic [2:0]  o_step,
    output logic        o_halted
);

    localparam logic [15:0] C_HLT = 16'h8000;
    localparam logic [15:0] C_MI  = 16'h4000;
    localparam logic [15:0] C_RI  = 16'h2000;
    localparam logic [15:0] C_RO  = 16'h1000;
    localparam logic [15:0] C_IO  = 16'h0800;
    localparam logic [15:0] C_II  = 16'h0400;
    localparam logic [15:0] C_AI  = 16'h0200;
    localparam logic [15:0] C_AO  = 16'h0100;
    localparam logic [15:0] C_EO  = 16'h0080;
    localparam logic [15:0] C_SU  = 16'h0040;
    localparam logic [15:0] C_BI  = 16'h0020;
    localparam logic [15:0] C_OI  = 16'h0010;
    localparam logic [15:0] C_CE  = 16'h0008;
    localparam logic [15:0] C_CO  = 16'h0004;
    localparam logic [15:0] C_J   = 16'h0002;
    localparam logic [15:0] C_FI  = 16'h0001;

    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_LDA = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_STA = 4'b0100;
    localparam logic [3:0] OP_LDI = 4'b0101;
    localparam logic [3:0] OP_JMP = 4'b0110;
    localparam logic [3:0] OP_JC  = 4'b0111;
    localparam logic [3:0] OP_JZ  = 4'b1000;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    localparam logic [2:0] STEP_CEIL = 3'(MAX_STEPS - 1);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t      r_state;
    logic [2:0]  r_step;
    logic        r_halted;
    logic [2:0]  w_last_step;
    logic        w_adv;
    logic        w_wrap;
    logic [15:0] w_ctrl;

`ifdef CTRL_SEQUENCER_SINGLE_STEP_EN
    logic r_btn_meta;
    logic r_btn_sync;
    logic r_btn_prev;
    logic w_btn_edge;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_btn_meta <= 1'b0;
            r_btn_sync <= 1'b0;
            r_btn_prev <= 1'b0;
        end else begin
            r_btn_meta <= i_step_btn;
            r_btn_sync <= r_btn_meta;
            r_btn_prev <= r_btn_sync;
        end
    end

    assign w_btn_edge  = r_btn_sync & ~r_btn_prev;
    assign w_adv       = ~i_step_mode | w_btn_edge;
    assign o_step_tick = w_btn_edge;
`else
    assign w_adv = 1'b1;
`endif

    // Index of the instruction's final step; only meaningful once the opcode is valid (T2+).
    always_comb begin
        w_last_step = 3'd2;
        case (i_opcode)
            OP_LDA, OP_STA: w_last_step = 3'd3;
            OP_ADD, OP_SUB: w_last_step = 3'd4;
            default:        w_last_step = 3'd2;
        endcase
        if (w_last_step > STEP_CEIL) begin
            w_last_step = STEP_CEIL;
        end
    end

    // Every instruction is at least three steps long, so T0/T1 never wrap.
    assign w_wrap = (r_step >= STEP_CEIL) ||
                    ((r_step >= 3'd2) && (r_step >= w_last_step));

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state  <= RESET_HALTED ? ST_HALT : ST_RUN;
            r_step   <= 3'd0;
            r_halted <= RESET_HALTED;
        end else if (w_adv) begin
            case (r_state)
                ST_RUN: begin
                    if ((r_step == 3'd2) && (i_opcode == OP_HLT)) begin
                        r_state  <= ST_HALT;
                        r_step   <= 3'd0;
                        r_halted <= 1'b1;
                    end else if (w_wrap) begin
                        r_step <= 3'd0;
                    end else begin
                        r_step <= r_step + 3'd1;
                    end
                end
                ST_HALT: begin
                    r_step <= 3'd0;
                    if (i_run) begin
                        r_state  <= ST_RUN;
                        r_halted <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= ST_HALT;
                    r_step   <= 3'd0;
                    r_halted <= 1'b1;
                end
            endcase
        end
    end

    // Microcode ROM; at most one of RO/IO/AO/EO/CO appears in any word.
    always_comb begin
        w_ctrl = 16'h0000;
        if (r_state == ST_RUN) begin
            case (r_step)
                3'd0: w_ctrl = C_CO | C_MI;
                3'd1: w_ctrl = C_RO | C_II | C_CE;
                3'd2: begin
                    case (i_opcode)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: w_ctrl = C_IO | C_MI;
                        OP_LDI: w_ctrl = C_IO | C_AI;
                        OP_JMP: w_ctrl = C_IO | C_J;
                        OP_JC:  w_ctrl = i_flag_c ? (C_IO | C_J) : 16'h0000;
                        OP_JZ:  w_ctrl = i_flag_z ? (C_IO | C_J) : 16'h0000;
                        OP_OUT: w_ctrl = C_AO | C_OI;
                        OP_HLT: w_ctrl = C_HLT;
                        OP_NOP: w_ctrl = 16'h0000;
                        default: w_ctrl = 16'h0000;
                    endcase
                end
                3'd3: begin
                    case (i_opcode)
                        OP_LDA:         w_ctrl = C_RO | C_AI;
                        OP_ADD, OP_SUB: w_ctrl = C_RO | C_BI;
                        OP_STA:         w_ctrl = C_AO | C_RI;
                        default:        w_ctrl = 16'h0000;
                    endcase
                end
                3'd4: begin
                    case (i_opcode)
                        OP_ADD:  w_ctrl = C_EO | C_AI | C_FI;
                        OP_SUB:  w_ctrl = C_EO | C_SU | C_AI | C_FI;
                        default: w_ctrl = 16'h0000;
                    endcase
                end
                default: w_ctrl = 16'h0000;
            endcase
        end
    end

    // Reset forces the control word quiet immediately, even though RUN/T0 is the reset state.
    assign o_ctrl   = i_rst ? w_ctrl : 16'h0000;
    assign o_step   = r_step;
    assign o_halted = r_halted;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Bench for ctrl_sequencer: directed scenarios plus random instruction streams,
// checked against an instruction-level model of the microcode.
module tb_ctrl_sequencer;

    logic        i_clk;
    logic        i_rst;
    logic [3:0]  i_opcode;
    logic        i_flag_c;
    logic        i_flag_z;
    logic        i_run;
    logic [15:0] o_ctrl;
    logic [2:0]  o_step;
    logic        o_halted;

    int n_checks;
    int n_errors;
    logic [15:0] exp_q[$];

    localparam logic [15:0] DRIVERS = 16'h1000 | 16'h0800 | 16'h0100 | 16'h0080 | 16'h0004;

    ctrl_sequencer dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_opcode (i_opcode),
        .i_flag_c (i_flag_c),
        .i_flag_z (i_flag_z),
        .i_run    (i_run),
        .o_ctrl   (o_ctrl),
        .o_step   (o_step),
        .o_halted (o_halted)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Bus-contention monitor, every cycle.
    always @(negedge i_clk) begin
        #2;
        check_eq("one_driver", 32'($countones(o_ctrl & DRIVERS) <= 1), 32'd1);
    end

    // Instruction-level reference: full list of control words for one instruction.
    task automatic load_expect(input logic [3:0] op, input logic fc, input logic fz);
        exp_q = {};
        exp_q.push_back(16'h4004);
        exp_q.push_back(16'h1408);
        case (op)
            4'h1: begin exp_q.push_back(16'h4800); exp_q.push_back(16'h1200); end
            4'h2: begin exp_q.push_back(16'h4800); exp_q.push_back(16'h1020); exp_q.push_back(16'h0281); end
            4'h3: begin exp_q.push_back(16'h4800); exp_q.push_back(16'h1020); exp_q.push_back(16'h02C1); end
            4'h4: begin exp_q.push_back(16'h4800); exp_q.push_back(16'h2100); end
            4'h5: exp_q.push_back(16'h0A00);
            4'h6: exp_q.push_back(16'h0802);
            4'h7: exp_q.push_back(fc ? 16'h0802 : 16'h0000);
            4'h8: exp_q.push_back(fz ? 16'h0802 : 16'h0000);
            4'hE: exp_q.push_back(16'h0110);
            4'hF: exp_q.push_back(16'h8000);
            default: exp_q.push_back(16'h0000);
        endcase
    endtask

    // Runs one instruction; stop_at < 0 runs it fully, else returns after checking that step.
    task automatic run_instr(input logic [3:0] op, input logic fc, input logic fz, input int stop_at);
        int k;
        logic [15:0] w;
        load_expect(op, fc, fz);
        k = 0;
        while (exp_q.size() > 0) begin
            w = exp_q.pop_front();
            @(negedge i_clk);
            i_opcode = op;
            i_flag_c = fc;
            i_flag_z = fz;
            i_run    = 1'($urandom_range(0, 1));
            #1;
            check_eq("ctrl", 32'(o_ctrl), 32'(w));
            check_eq("step", 32'(o_step), k);
            check_eq("halted_run", 32'(o_halted), 32'd0);
            if (k == stop_at) return;
            k++;
        end
    endtask

    task automatic run_halt(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge i_clk);
            i_run    = 1'b0;
            i_opcode = 4'($urandom_range(0, 15));
            #1;
            check_eq("halt_ctrl", 32'(o_ctrl), 32'd0);
            check_eq("halt_step", 32'(o_step), 32'd0);
            check_eq("halted", 32'(o_halted), 32'd1);
        end
        @(negedge i_clk);
        i_run = 1'b1;
        #1;
        check_eq("halted_wake", 32'(o_halted), 32'd1);
    endtask

    initial begin
        logic [3:0] op;
        logic       fc;
        logic       fz;
        n_checks = 0;
        n_errors = 0;
        i_rst    = 1'b0;
        i_opcode = 4'h1;
        i_flag_c = 1'b0;
        i_flag_z = 1'b0;
        i_run    = 1'b0;

        @(negedge i_clk);
        #1;
        check_eq("rst_ctrl", 32'(o_ctrl), 32'd0);
        check_eq("rst_step", 32'(o_step), 32'd0);
        check_eq("rst_halted", 32'(o_halted), 32'd0);
        @(posedge i_clk);
        #2 i_rst = 1'b1;

        run_instr(4'h1, 1'b0, 1'b0, -1);
        run_instr(4'h2, 1'b0, 1'b0, -1);
        run_instr(4'h3, 1'b1, 1'b1, -1);
        run_instr(4'h7, 1'b0, 1'b0, -1);
        run_instr(4'h7, 1'b1, 1'b0, -1);
        run_instr(4'h8, 1'b0, 1'b0, -1);
        run_instr(4'h8, 1'b0, 1'b1, -1);
        run_instr(4'h4, 1'b0, 1'b0, -1);
        run_instr(4'h9, 1'b0, 1'b0, -1);
        run_instr(4'hF, 1'b0, 1'b0, -1);
        run_halt(10);
        run_instr(4'h1, 1'b0, 1'b0, -1);

        // Reset in the middle of ADD at T3.
        run_instr(4'h2, 1'b0, 1'b0, 3);
        i_rst = 1'b0;
        #1;
        check_eq("midrst_ctrl", 32'(o_ctrl), 32'd0);
        check_eq("midrst_step", 32'(o_step), 32'd0);
        check_eq("midrst_halted", 32'(o_halted), 32'd0);
        @(posedge i_clk);
        #2 i_rst = 1'b1;
        run_instr(4'h2, 1'b0, 1'b0, -1);

        for (int n = 0; n < 150; n++) begin
            op = 4'($urandom_range(0, 15));
            fc = 1'($urandom_range(0, 1));
            fz = 1'($urandom_range(0, 1));
            run_instr(op, fc, fz, -1);
            if (op == 4'hF) run_halt(int'($urandom_range(1, 5)));
        end

        @(negedge i_clk);
        #3;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
